// File: rtl/packet_parser.sv
// Sink-side data-island packet parser: captures BCH-checked packets, decodes ACR and AVI
// contents, and unpacks audio sample packets into a first-word fall-through FIFO.
module packet_parser #(
  parameter int unsigned AUDIO_BIT_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                            clk_pixel,
  input  logic                            reset_n,
  input  logic                            packet_valid,
  input  logic                            packet_error,
  input  logic [23:0]                     header,
  input  logic [3:0][55:0]                sub,
  output logic                            audio_valid,
  input  logic                            audio_ready,
  output logic [1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word,
  output logic                            audio_block_start,
  output logic [19:0]                     acr_n,
  output logic [19:0]                     acr_cts,
  output logic                            acr_update,
  output logic [6:0]                      video_id_code,
  output logic                            avi_valid,
  output logic                            checksum_error,
  output logic                            parity_error,
  output logic [7:0]                      dropped_samples
);

  localparam int unsigned W      = AUDIO_BIT_WIDTH;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned EntryW = 2 * W + 1;

  typedef enum logic [0:0] {StIdle, StUnpack} state_e;

  logic                  pkt_accept;
  logic [23:0]           hdr_q;
  logic [3:0][55:0]      sub_q;
  logic                  pkt_new_q;
  logic [7:0]            pkt_type;
  logic [3:0]            hb1_present;
  logic [3:0]            hb2_block;
  logic [7:0]            csum;

  state_e                state_q;
  logic [1:0]            slot_q;
  logic [55:0]           slot_data;
  logic                  parity_bad;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  full;
  logic                  overflow_drop;
  logic [2:0]            preempt_cnt;
  logic [8:0]            drop_sum;
  logic [EntryW-1:0]     entry;
  logic [EntryW-1:0]     head;

  logic [EntryW-1:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [PtrW:0]         count_q;

  assign pkt_accept  = packet_valid && !packet_error;
  assign pkt_type    = hdr_q[7:0];
  assign hb1_present = hdr_q[11:8];
  assign hb2_block   = hdr_q[23:20];

  // Packet buffer data; validity is tracked separately by pkt_new_q.
  always_ff @(posedge clk_pixel) begin
    if (pkt_accept) begin
      hdr_q <= header;
      sub_q <= sub;
    end
  end

  // One-cycle flag marking a freshly loaded buffer for dispatch.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) pkt_new_q <= 1'b0;
    else          pkt_new_q <= pkt_accept;
  end

  // InfoFrame checksum over the three header bytes and all 28 subpacket bytes.
  always_comb begin
    csum = hdr_q[7:0] + hdr_q[15:8] + hdr_q[23:16];
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 7; b++) begin
        csum = csum + sub_q[i][8*b +: 8];
      end
    end
  end

  // ACR and InfoFrame field updates, one cycle after the buffer loads.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      acr_n          <= '0;
      acr_cts        <= '0;
      acr_update     <= 1'b0;
      video_id_code  <= '0;
      avi_valid      <= 1'b0;
      checksum_error <= 1'b0;
    end else begin
      acr_update     <= 1'b0;
      checksum_error <= 1'b0;
      if (pkt_new_q) begin
        if (pkt_type == 8'h01) begin
          acr_cts    <= {sub_q[0][11:8], sub_q[0][23:16], sub_q[0][31:24]};
          acr_n      <= {sub_q[0][35:32], sub_q[0][47:40], sub_q[0][55:48]};
          acr_update <= 1'b1;
        end
        if (pkt_type[7:4] == 4'h8) begin
          if (csum != 8'h00) begin
            checksum_error <= 1'b1;
          end else if (pkt_type == 8'h82) begin
            video_id_code <= sub_q[0][38:32];
            avi_valid     <= 1'b1;
          end
        end
      end
    end
  end

  // Unpack FSM: walks slots 0..3 of the buffered audio packet, one per cycle.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state_q <= StIdle;
      slot_q  <= 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A packet accepted on the start cycle overwrites the buffer, so do not start.
          if (pkt_new_q && pkt_type == 8'h02 && !pkt_accept) begin
            state_q <= StUnpack;
            slot_q  <= 2'd0;
          end
        end
        StUnpack: begin
          if (pkt_accept || slot_q == 2'd3) state_q <= StIdle;
          else                              slot_q  <= slot_q + 2'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign slot_data  = sub_q[slot_q];
  assign parity_bad = ((^slot_data[23:0]) ^ (^slot_data[51:48])) |
                      ((^slot_data[47:24]) ^ (^slot_data[55:52]));
  assign push_req   = (state_q == StUnpack) && hb1_present[slot_q];
  assign entry      = {hb2_block[slot_q], slot_data[23 -: W], slot_data[47 -: W]};

  // Count depth is a power of two, so the count MSB alone flags full.
  assign full          = count_q[PtrW];
  assign pop           = audio_valid && audio_ready;
  assign push_ok       = push_req && (!full || pop);
  assign overflow_drop = push_req && !push_ok;

  // Slots not yet handled when a new packet preempts; the current slot is still processed.
  always_comb begin
    preempt_cnt = '0;
    if (pkt_accept) begin
      if (state_q == StUnpack) begin
        for (int i = 0; i < 4; i++) begin
          if (2'(i) > slot_q && hb1_present[i]) preempt_cnt = preempt_cnt + 3'd1;
        end
      end else if (pkt_new_q && pkt_type == 8'h02) begin
        for (int i = 0; i < 4; i++) begin
          if (hb1_present[i]) preempt_cnt = preempt_cnt + 3'd1;
        end
      end
    end
  end

  assign drop_sum = {1'b0, dropped_samples} + {6'd0, preempt_cnt} + {8'd0, overflow_drop};

  // Drop counter and parity pulse, aligned with the slot's push cycle.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      dropped_samples <= '0;
      parity_error    <= 1'b0;
    end else begin
      dropped_samples <= drop_sum[8] ? 8'hff : drop_sum[7:0];
      parity_error    <= push_req && parity_bad;
    end
  end

  // FIFO storage; contents need no reset because the head is gated by audio_valid.
  always_ff @(posedge clk_pixel) begin
    if (push_ok) mem_q[wr_ptr_q] <= entry;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
    end
  end

  assign head                 = mem_q[rd_ptr_q];
  assign audio_valid          = (count_q != '0);
  assign audio_sample_word[0] = audio_valid ? head[2*W-1:W] : '0;
  assign audio_sample_word[1] = audio_valid ? head[W-1:0]   : '0;
  assign audio_block_start    = audio_valid & head[2*W];

endmodule

// File: tb/tb_packet_parser.sv
// Bench for packet_parser: directed scenarios plus randomized packets checked against a
// queue-based model of the packet rules. A 16-bit-wide instance shares the stimulus.
module tb_packet_parser;

  localparam int unsigned Depth = 8;

  logic clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  logic             reset_n, packet_valid, packet_error, audio_ready;
  logic [23:0]      header;
  logic [3:0][55:0] sub;

  logic             audio_valid, audio_block_start, acr_update, avi_valid;
  logic             checksum_error, parity_error;
  logic [1:0][23:0] audio_sample_word;
  logic [19:0]      acr_n, acr_cts;
  logic [6:0]       video_id_code;
  logic [7:0]       dropped_samples;

  logic             audio_valid_w16, audio_block_start_w16, acr_update_w16, avi_valid_w16;
  logic             checksum_error_w16, parity_error_w16;
  logic [1:0][15:0] audio_sample_word_w16;
  logic [19:0]      acr_n_w16, acr_cts_w16;
  logic [6:0]       video_id_code_w16;
  logic [7:0]       dropped_samples_w16;

  packet_parser #(.AUDIO_BIT_WIDTH(24), .FIFO_DEPTH(Depth)) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_valid(packet_valid),
    .packet_error(packet_error), .header(header), .sub(sub), .audio_valid(audio_valid),
    .audio_ready(audio_ready), .audio_sample_word(audio_sample_word),
    .audio_block_start(audio_block_start), .acr_n(acr_n), .acr_cts(acr_cts),
    .acr_update(acr_update), .video_id_code(video_id_code), .avi_valid(avi_valid),
    .checksum_error(checksum_error), .parity_error(parity_error),
    .dropped_samples(dropped_samples)
  );

  packet_parser #(.AUDIO_BIT_WIDTH(16), .FIFO_DEPTH(Depth)) dut16 (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_valid(packet_valid),
    .packet_error(packet_error), .header(header), .sub(sub), .audio_valid(audio_valid_w16),
    .audio_ready(audio_ready), .audio_sample_word(audio_sample_word_w16),
    .audio_block_start(audio_block_start_w16), .acr_n(acr_n_w16), .acr_cts(acr_cts_w16),
    .acr_update(acr_update_w16), .video_id_code(video_id_code_w16),
    .avi_valid(avi_valid_w16), .checksum_error(checksum_error_w16),
    .parity_error(parity_error_w16), .dropped_samples(dropped_samples_w16)
  );

  typedef struct packed {
    logic        b;
    logic [23:0] l;
    logic [23:0] r;
  } sample_t;

  sample_t     exp_q[$];
  logic [19:0] m_acr_n, m_acr_cts;
  logic [6:0]  m_vic;
  logic        m_avi;
  int          m_drop;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pkt_sum(input logic [23:0] h, input logic [3:0][55:0] s);
    logic [7:0] acc;
    acc = h[7:0] + h[15:8] + h[23:16];
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 7; b++) acc = acc + s[i][8*b +: 8];
    return acc;
  endfunction

  // Builds one subpacket whose status nibbles give even parity, unless bad is set.
  function automatic logic [55:0] make_slot(input logic [23:0] l, input logic [23:0] r,
                                            input logic bad);
    logic [3:0] xl, xr;
    xl = 4'($urandom());
    xr = 4'($urandom());
    xl[0] = (^l) ^ (^xl[3:1]);
    xr[0] = (^r) ^ (^xr[3:1]);
    if (bad) l = l ^ (24'd1 << $urandom_range(0, 23));
    return {xr, xl, r, l};
  endfunction

  function automatic logic slot_bad(input logic [55:0] s);
    return ((^s[23:0]) ^ (^s[51:48])) | ((^s[47:24]) ^ (^s[55:52]));
  endfunction

  task automatic build_acr(input logic [19:0] n, input logic [19:0] cts,
                           output logic [23:0] h, output logic [3:0][55:0] s);
    h = 24'h000001;
    for (int i = 1; i < 4; i++) s[i] = 56'({$urandom(), $urandom()});
    s[0] = {n[7:0], n[15:8], 4'h0, n[19:16], cts[7:0], cts[15:8], 4'h0, cts[19:16], 8'h00};
  endtask

  task automatic build_info(input logic [7:0] typ, input logic [6:0] vic,
                            output logic [23:0] h, output logic [3:0][55:0] s);
    h = {8'd13, 8'd2, typ};
    for (int i = 0; i < 4; i++) s[i] = 56'({$urandom(), $urandom()});
    s[0][39:32] = {1'b0, vic};
    s[0][7:0]   = 8'h00;
    s[0][7:0]   = 8'h00 - pkt_sum(h, s);
  endtask

  task automatic build_audio(input logic [3:0] present, input logic [3:0] bflags,
                             input logic [3:0] bad, output logic [23:0] h,
                             output logic [3:0][55:0] s);
    h = {bflags, 4'h0, 4'h0, present, 8'h02};
    for (int i = 0; i < 4; i++) s[i] = make_slot(24'($urandom()), 24'($urandom()), bad[i]);
  endtask

  task automatic drop_one();
    m_drop = (m_drop < 255) ? m_drop + 1 : 255;
  endtask

  // Applies one accepted packet to the model; slots at or past nslots are preempted.
  task automatic model_pkt(input logic [23:0] h, input logic [3:0][55:0] s, input logic err,
                           input int nslots, output logic upd, output logic chk,
                           output logic [3:0] par);
    upd = 1'b0;
    chk = 1'b0;
    par = '0;
    if (!err) begin
      if (h[7:0] == 8'h01) begin
        m_acr_cts = {s[0][11:8], s[0][23:16], s[0][31:24]};
        m_acr_n   = {s[0][35:32], s[0][47:40], s[0][55:48]};
        upd = 1'b1;
      end
      if (h[7:4] == 4'h8) begin
        if (pkt_sum(h, s) != 8'h00) chk = 1'b1;
        else if (h[7:0] == 8'h82) begin
          m_vic = s[0][38:32];
          m_avi = 1'b1;
        end
      end
      if (h[7:0] == 8'h02) begin
        for (int i = 0; i < 4; i++) begin
          if (h[8+i]) begin
            if (i < nslots) begin
              par[i] = slot_bad(s[i]);
              if (exp_q.size() < Depth) exp_q.push_back({h[20+i], s[i][23:0], s[i][47:24]});
              else drop_one();
            end else begin
              drop_one();
            end
          end
        end
      end
    end
  endtask

  // Drives one packet for a single cycle; returns between the accept edge and the next.
  task automatic put_pkt(input logic [23:0] h, input logic [3:0][55:0] s, input logic err);
    header       = h;
    sub          = s;
    packet_error = err;
    packet_valid = 1'b1;
    @(negedge clk_pixel);
    packet_valid = 1'b0;
    packet_error = 1'b0;
  endtask

  task automatic send_pkt(input string tag, input logic [23:0] h,
                          input logic [3:0][55:0] s, input logic err);
    logic       upd, chk, was_empty;
    logic [3:0] par;
    was_empty = (exp_q.size() == 0);
    model_pkt(h, s, err, 4, upd, chk, par);
    @(negedge clk_pixel);
    put_pkt(h, s, err);
    @(negedge clk_pixel);
    check({tag, ":acr_update"}, acr_update, upd);
    check({tag, ":checksum_error"}, checksum_error, chk);
    check({tag, ":acr_n"}, acr_n, m_acr_n);
    check({tag, ":acr_cts"}, acr_cts, m_acr_cts);
    check({tag, ":video_id_code"}, video_id_code, m_vic);
    check({tag, ":avi_valid"}, avi_valid, m_avi);
    if (was_empty) check({tag, ":valid_early"}, audio_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_pixel);
      check({tag, $sformatf(":parity_slot%0d", i)}, parity_error, par[i]);
      check({tag, ":parity_w16"}, parity_error_w16, par[i]);
      check({tag, ":acr_update_end"}, acr_update, 1'b0);
      check({tag, ":checksum_end"}, checksum_error, 1'b0);
      if (i == 0 && was_empty)
        check({tag, ":valid_first"}, audio_valid, !err && h[7:0] == 8'h02 && h[8]);
    end
    @(negedge clk_pixel);
    check({tag, ":dropped"}, dropped_samples, 8'(m_drop));
  endtask

  task automatic check_head(input string tag, input sample_t e);
    check({tag, ":valid"}, audio_valid, 1'b1);
    check({tag, ":left"}, audio_sample_word[0], e.l);
    check({tag, ":right"}, audio_sample_word[1], e.r);
    check({tag, ":block"}, audio_block_start, e.b);
    check({tag, ":left_w16"}, audio_sample_word_w16[0], e.l[23:8]);
    check({tag, ":right_w16"}, audio_sample_word_w16[1], e.r[23:8]);
  endtask

  task automatic drain(input string tag);
    sample_t e;
    int      n;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_head({tag, $sformatf(":pop%0d", n)}, e);
      if (n == 0) begin
        @(negedge clk_pixel);
        check_head({tag, ":stall"}, e);
      end
      audio_ready = 1'b1;
      @(negedge clk_pixel);
      audio_ready = 1'b0;
      n++;
    end
    check({tag, ":empty"}, audio_valid, 1'b0);
    check({tag, ":empty_w16"}, audio_valid_w16, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ":audio_valid"}, audio_valid, 1'b0);
    check({tag, ":word"}, audio_sample_word, 48'h0);
    check({tag, ":block"}, audio_block_start, 1'b0);
    check({tag, ":acr_n"}, acr_n, 20'h0);
    check({tag, ":acr_cts"}, acr_cts, 20'h0);
    check({tag, ":acr_update"}, acr_update, 1'b0);
    check({tag, ":vic"}, video_id_code, 7'h0);
    check({tag, ":avi_valid"}, avi_valid, 1'b0);
    check({tag, ":checksum_error"}, checksum_error, 1'b0);
    check({tag, ":parity_error"}, parity_error, 1'b0);
    check({tag, ":dropped"}, dropped_samples, 8'h0);
    check({tag, ":audio_valid_w16"}, audio_valid_w16, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_acr_n   = '0;
    m_acr_cts = '0;
    m_vic     = '0;
    m_avi     = 1'b0;
    m_drop    = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0]      h, hb;
    logic [3:0][55:0] s, sb;
    logic             upd, chk;
    logic [3:0]       par;
    int               kind;

    reset_n      = 1'b0;
    packet_valid = 1'b0;
    packet_error = 1'b0;
    audio_ready  = 1'b0;
    header       = '0;
    sub          = '0;
    model_reset();
    repeat (2) @(negedge clk_pixel);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk_pixel);

    // ACR: N = 0x01800, CTS = 0x06978.
    build_acr(20'h01800, 20'h06978, h, s);
    send_pkt("acr", h, s, 1'b0);
    check("acr:n_const", acr_n, 20'h01800);
    check("acr:cts_const", acr_cts, 20'h06978);

    // AVI with VIC 16, then the same packet with PB0 bumped.
    build_info(8'h82, 7'd16, h, s);
    send_pkt("avi", h, s, 1'b0);
    check("avi:vic_const", video_id_code, 7'd16);
    check("avi:valid_const", avi_valid, 1'b1);
    s[0][7:0] = s[0][7:0] + 8'd1;
    send_pkt("avi_bad", h, s, 1'b0);
    check("avi_bad:vic_kept", video_id_code, 7'd16);

    // Audio: four samples, block start on slot 0.
    build_audio(4'hf, 4'h0, 4'h0, h, s);
    h[23:16] = 8'h10;
    s[0] = make_slot(24'h123456, 24'habcdef, 1'b0);
    send_pkt("audio", h, s, 1'b0);
    check("audio:first_left", audio_sample_word[0], 24'h123456);
    check("audio:first_right", audio_sample_word[1], 24'habcdef);
    check("audio:first_left_w16", audio_sample_word_w16[0], 16'h1234);
    check("audio:first_block", audio_block_start, 1'b1);
    drain("audio_drain");

    // Overflow: three full packets into an 8-entry FIFO with no consumer.
    for (int p = 0; p < 3; p++) begin
      build_audio(4'hf, 4'($urandom()), 4'h0, h, s);
      send_pkt($sformatf("ovf%0d", p), h, s, 1'b0);
    end
    check("ovf:dropped_const", dropped_samples, 8'd4);
    drain("ovf_drain");

    // Preemption: second packet accepted two cycles into the first packet's unpack.
    build_audio(4'h7, 4'($urandom()), 4'h0, h, s);
    build_audio(4'hf, 4'($urandom()), 4'h0, hb, sb);
    model_pkt(h, s, 1'b0, 2, upd, chk, par);
    model_pkt(hb, sb, 1'b0, 4, upd, chk, par);
    @(negedge clk_pixel);
    put_pkt(h, s, 1'b0);
    repeat (2) @(negedge clk_pixel);
    put_pkt(hb, sb, 1'b0);
    repeat (8) @(negedge clk_pixel);
    check("preempt:dropped", dropped_samples, 8'(m_drop));
    check("preempt:dropped_const", dropped_samples, 8'd5);
    drain("preempt_drain");

    // Errored packets leave every output alone.
    build_acr(20'h12345, 20'h54321, h, s);
    send_pkt("err_acr", h, s, 1'b1);
    build_audio(4'hf, 4'hf, 4'h0, h, s);
    send_pkt("err_audio", h, s, 1'b1);

    // Parity failure on slot 2 only.
    build_audio(4'hf, 4'h0, 4'b0100, h, s);
    send_pkt("parity", h, s, 1'b0);
    drain("parity_drain");

    // Randomized mix of packet types.
    for (int it = 0; it < 30; it++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0: build_acr(20'($urandom()), 20'($urandom()), h, s);
        1: build_info(8'h82, 7'($urandom()), h, s);
        2: begin
          build_info(8'h82, 7'($urandom()), h, s);
          s[0][7:0] = s[0][7:0] + 8'($urandom_range(1, 255));
        end
        3: begin
          if (exp_q.size() > Depth - 4) drain($sformatf("rnd%0d_predrain", it));
          build_audio(4'($urandom()), 4'($urandom()),
                      {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0}, h, s);
        end
        4: begin
          if (exp_q.size() > Depth - 4) drain($sformatf("rnd%0d_predrain", it));
          build_audio(4'hf, 4'($urandom()), 4'h0, h, s);
          if ($urandom_range(0, 1) == 1) build_acr(20'($urandom()), 20'($urandom()), h, s);
        end
        default: begin
          if ($urandom_range(0, 1) == 1) build_info(8'h84, 7'($urandom()), h, s);
          else build_acr(20'($urandom()), 20'($urandom()), h, s);
          h[7:0] = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'h03;
          if ($urandom_range(0, 1) == 1) build_info(8'h84, 7'($urandom()), h, s);
        end
      endcase
      send_pkt($sformatf("rnd%0d_k%0d", it, kind), h, s, kind == 4);
      if ($urandom_range(0, 3) == 0) drain($sformatf("rnd%0d_drain", it));
    end
    drain("rnd_final");

    // Reset two edges into an unpack.
    build_audio(4'hf, 4'h1, 4'h0, h, s);
    @(negedge clk_pixel);
    put_pkt(h, s, 1'b0);
    repeat (2) @(negedge clk_pixel);
    check("rst_mid:valid_before", audio_valid, 1'b1);
    reset_n = 1'b0;
    @(negedge clk_pixel);
    model_reset();
    check_reset_values("rst_mid");
    reset_n = 1'b1;
    repeat (6) @(negedge clk_pixel);
    check("rst_mid:no_push", audio_valid, 1'b0);
    check("rst_mid:dropped", dropped_samples, 8'h0);
    check("rst_mid:parity", parity_error, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
